// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong geometry, game-state codes and collision FSM encoding
// Purpose: constants and enums used by the collision detector and its helpers.
// Ports: none (package).
package pong_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int BALL_SIZE = 32;
    localparam int BORDER    = 8;
    localparam int PAD_W     = 8;
    localparam int PAD_H     = 64;
    localparam int PAD1_X    = 16;
    localparam int PAD2_X    = 616;

    // Every coordinate sum is carried in 11 bits so nothing wraps.
    localparam int COORD_W   = 11;

    typedef enum logic [1:0] {
        GS_START = 2'd0,
        GS_SERVE = 2'd1,
        GS_PLAY  = 2'd2,
        GS_DONE  = 2'd3
    } game_state_e;

    typedef enum logic [1:0] {
        DET_SYNC   = 2'd0,
        DET_SCAN   = 2'd1,
        DET_REPORT = 2'd2
    } det_state_e;

endpackage

// File: rtl/rect_hit.sv
// rtl/rect_hit.sv - combinational point-in-rectangle test for a paddle
// Purpose: o_hit = 1 when (i_x, i_y) lies in [X0, X0+W) x [i_top, i_top+H).
// Ports:
//   i_x, i_y  point under test (11-bit, zero-extended)
//   i_top     top row of the rectangle (11-bit, zero-extended)
//   o_hit     point is inside the rectangle
module rect_hit
    import pong_pkg::*;
#(
    parameter int X0 = PAD1_X,
    parameter int W  = PAD_W,
    parameter int H  = PAD_H
) (
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [COORD_W-1:0] i_top,
    output logic               o_hit
);

    logic [COORD_W-1:0] w_bottom;

    assign w_bottom = i_top + COORD_W'(H);

    assign o_hit = (i_y >= i_top) && (i_y < w_bottom) &&
                   (i_x >= COORD_W'(X0)) && (i_x < COORD_W'(X0 + W));

endmodule

// File: rtl/collision_detect.sv
// rtl/collision_detect.sv - per-frame ball collision flags and score strobes for Pong
// Purpose: compares the scan position with four ball probe pixels, accumulates
//   sticky hit flags over a frame while in PLAY, and reports them in a one-cycle
//   ResetCollision strobe at frame end together with the score strobes.
// Ports:
//   clk, rst                     pixel clock, async active-low reset
//   state                        game state (START/SERVE/PLAY/DONE)
//   hcount, vcount, video_on     scan position and active-area flag
//   ballX, ballY                 ball top-left corner
//   paddle1Y, paddle2Y           paddle top rows
//   CollisionX1/X2/Y1/Y2         sticky probe flags (left/right/top/bottom)
//   ResetCollision               frame-end strobe, flags valid this cycle
//   ScoreP1, ScoreP2             point strobes coincident with ResetCollision
module collision_detect
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       video_on,
    input  logic [9:0] ballX,
    input  logic [8:0] ballY,
    input  logic [8:0] paddle1Y,
    input  logic [8:0] paddle2Y,
    output logic       CollisionX1,
    output logic       CollisionX2,
    output logic       CollisionY1,
    output logic       CollisionY2,
    output logic       ResetCollision,
    output logic       ScoreP1,
    output logic       ScoreP2
);

    localparam logic [COORD_W-1:0] C_MID = COORD_W'(BALL_SIZE / 2);
    localparam logic [COORD_W-1:0] C_FAR = COORD_W'(BALL_SIZE - 1);

    logic [COORD_W-1:0] w_h, w_v, w_bx, w_by;
    logic [COORD_W-1:0] w_x_left, w_x_right, w_x_mid, w_y_top, w_y_bottom, w_y_mid;
    logic               w_wall, w_pad1, w_pad2, w_obstacle;
    logic               w_play, w_frame_start, w_frame_end;
    logic [3:0]         w_hit;

    det_state_e         r_fsm;
    logic [3:0]         r_hit_q;   // bit 0 X1, 1 X2, 2 Y1, 3 Y2
    logic [3:0]         r_flags;
    logic               r_reset_collision;
    logic               r_score_p1;
    logic               r_score_p2;

    assign w_h  = {1'b0, hcount};
    assign w_v  = {1'b0, vcount};
    assign w_bx = {1'b0, ballX};
    assign w_by = {2'b00, ballY};

    assign w_x_left   = w_bx;
    assign w_x_right  = w_bx + C_FAR;
    assign w_x_mid    = w_bx + C_MID;
    assign w_y_top    = w_by;
    assign w_y_bottom = w_by + C_FAR;
    assign w_y_mid    = w_by + C_MID;

    assign w_wall = (w_v < COORD_W'(BORDER)) || (w_v >= COORD_W'(V_ACTIVE - BORDER));

    rect_hit #(.X0(PAD1_X), .W(PAD_W), .H(PAD_H)) u_pad1 (
        .i_x   (w_h),
        .i_y   (w_v),
        .i_top ({2'b00, paddle1Y}),
        .o_hit (w_pad1)
    );

    rect_hit #(.X0(PAD2_X), .W(PAD_W), .H(PAD_H)) u_pad2 (
        .i_x   (w_h),
        .i_y   (w_v),
        .i_top ({2'b00, paddle2Y}),
        .o_hit (w_pad2)
    );

    assign w_obstacle = video_on && (w_wall || w_pad1 || w_pad2);

    assign w_hit[0] = w_obstacle && (w_h == w_x_left)  && (w_v == w_y_mid);
    assign w_hit[1] = w_obstacle && (w_h == w_x_right) && (w_v == w_y_mid);
    assign w_hit[2] = w_obstacle && (w_h == w_x_mid)   && (w_v == w_y_top);
    assign w_hit[3] = w_obstacle && (w_h == w_x_mid)   && (w_v == w_y_bottom);

    assign w_play        = (state == GS_PLAY);
    assign w_frame_start = (hcount == 10'd0) && (vcount == 10'd0);
    assign w_frame_end   = (hcount == 10'd0) && (vcount == 10'(V_ACTIVE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm             <= DET_SYNC;
            r_hit_q           <= '0;
            r_flags           <= '0;
            r_reset_collision <= 1'b0;
            r_score_p1        <= 1'b0;
            r_score_p2        <= 1'b0;
        end else begin
            r_reset_collision <= 1'b0;
            r_score_p1        <= 1'b0;
            r_score_p2        <= 1'b0;

            case (r_fsm)
                DET_SYNC: begin
                    if (w_frame_start) r_fsm <= DET_SCAN;
                end
                DET_SCAN: begin
                    if (w_frame_end) begin
                        r_fsm             <= DET_REPORT;
                        r_reset_collision <= 1'b1;
                        r_score_p2        <= w_play && (ballX == 10'd0);
                        r_score_p1        <= w_play && (w_bx >= COORD_W'(H_ACTIVE - BALL_SIZE));
                    end
                end
                DET_REPORT: r_fsm <= DET_SCAN;
                default:    r_fsm <= DET_SYNC;
            endcase

            // The pixel seen during REPORT is dropped so the next frame starts clean.
            if (!w_play || r_fsm == DET_REPORT) r_hit_q <= '0;
            else                                r_hit_q <= w_hit;

            // Accumulate only while scanning: SYNC discards the partial frame and
            // the edge leaving REPORT clears, so flags hold steady through REPORT.
            if (!w_play || r_fsm != DET_SCAN) r_flags <= '0;
            else                              r_flags <= r_flags | r_hit_q;
        end
    end

    assign CollisionX1    = r_flags[0];
    assign CollisionX2    = r_flags[1];
    assign CollisionY1    = r_flags[2];
    assign CollisionY2    = r_flags[3];
    assign ResetCollision = r_reset_collision;
    assign ScoreP1        = r_score_p1;
    assign ScoreP2        = r_score_p2;

endmodule

// File: tb/tb_collision_detect.sv
// tb/tb_collision_detect.sv - self-checking bench for collision_detect
module tb_collision_detect;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state;
    logic [9:0] hcount, vcount;
    logic       video_on;
    logic [9:0] ballX;
    logic [8:0] ballY, paddle1Y, paddle2Y;
    logic       CollisionX1, CollisionX2, CollisionY1, CollisionY2;
    logic       ResetCollision, ScoreP1, ScoreP2;

    collision_detect dut (
        .clk            (clk),
        .rst            (rst),
        .state          (state),
        .hcount         (hcount),
        .vcount         (vcount),
        .video_on       (video_on),
        .ballX          (ballX),
        .ballY          (ballY),
        .paddle1Y       (paddle1Y),
        .paddle2Y       (paddle2Y),
        .CollisionX1    (CollisionX1),
        .CollisionX2    (CollisionX2),
        .CollisionY1    (CollisionY1),
        .CollisionY2    (CollisionY2),
        .ResetCollision (ResetCollision),
        .ScoreP1        (ScoreP1),
        .ScoreP2        (ScoreP2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scenario parameters (game state code: 0 START, 1 SERVE, 2 PLAY, 3 DONE)
    int bx, by, p1y, p2y, gs;
    bit exp_f [4];   // expected X1, X2, Y1, Y2
    bit early;

    wire [3:0] got_flags = {CollisionY2, CollisionY1, CollisionX2, CollisionX1};
    wire [6:0] all_out   = {ResetCollision, ScoreP1, ScoreP2, got_flags};

    task automatic apply_scene();
        state    = gs[1:0];
        ballX    = bx[9:0];
        ballY    = by[8:0];
        paddle1Y = p1y[8:0];
        paddle2Y = p2y[8:0];
    endtask

    // Scene rules written directly from the game description.
    function automatic bit is_obstacle(int h, int v, bit von);
        bit on_p1, on_p2;
        on_p1 = (v >= p1y) && (v < p1y + 64) && (h >= 16)  && (h < 24);
        on_p2 = (v >= p2y) && (v < p2y + 64) && (h >= 616) && (h < 624);
        return von && ((v < 8) || (v >= 472) || on_p1 || on_p2);
    endfunction

    function automatic int probe_x(int k);
        if (k == 0) return bx;
        if (k == 1) return bx + 31;
        return bx + 16;
    endfunction

    function automatic int probe_y(int k);
        if (k == 2) return by;
        if (k == 3) return by + 31;
        return by + 16;
    endfunction

    // One scan cycle at (h, v); the model records which probes saw an obstacle.
    task automatic pix(input int h, input int v);
        bit von;
        von      = (h < 640) && (v < 480);
        hcount   = h[9:0];
        vcount   = v[9:0];
        video_on = von;
        @(posedge clk);
        #1;
        if (gs == 2)
            for (int k = 0; k < 4; k++)
                if (probe_x(k) == h && probe_y(k) == v && is_obstacle(h, v, von))
                    exp_f[k] = 1'b1;
        if (ResetCollision !== 1'b0) early = 1'b1;
    endtask

    task automatic begin_frame();
        for (int k = 0; k < 4; k++) exp_f[k] = 1'b0;
        early = 1'b0;
        pix(0, 0);
    endtask

    task automatic end_frame(input string name);
        logic [3:0] ef;
        logic [1:0] es;
        pix(700, 479);
        total++;
        if (early) begin
            bad++;
            $display("FAIL %s early_pulse: ResetCollision=1 seen before frame end, required 0", name);
        end
        hcount = 10'd0; vcount = 10'd480; video_on = 1'b0;
        @(posedge clk);
        #1;
        ef = {exp_f[3], exp_f[2], exp_f[1], exp_f[0]};
        es = {(gs == 2) && (bx >= 608), (gs == 2) && (bx == 0)};
        total++;
        if (ResetCollision !== 1'b1) begin
            bad++;
            $display("FAIL %s pulse: ResetCollision=%b required 1", name, ResetCollision);
        end
        total++;
        if (got_flags !== ef) begin
            bad++;
            $display("FAIL %s flags(Y2Y1X2X1): got %b required %b", name, got_flags, ef);
        end
        total++;
        if ({ScoreP1, ScoreP2} !== es) begin
            bad++;
            $display("FAIL %s score(P1P2): got %b required %b", name, {ScoreP1, ScoreP2}, es);
        end
        hcount = 10'd1;
        @(posedge clk);
        #1;
        total++;
        if (all_out !== 7'd0) begin
            bad++;
            $display("FAIL %s after_pulse: outputs %b required 0000000", name, all_out);
        end
    endtask

    task automatic run_frame(input string name, input int nrand);
        apply_scene();
        begin_frame();
        for (int k = 0; k < 4; k++)
            if (probe_x(k) < 640 && probe_y(k) < 480) pix(probe_x(k), probe_y(k));
        for (int i = 0; i < nrand; i++)
            pix($urandom_range(0, 799), $urandom_range(1, 479));
        end_frame(name);
    endtask

    task automatic test_reset();
        bit quiet;
        int hs [7] = '{5, 16, 30, 700, 0, 1, 100};
        int vs [7] = '{200, 472, 300, 479, 480, 480, 10};
        rst = 1'b0;
        gs = 2; bx = 0; by = 441; p1y = 100; p2y = 300;
        apply_scene();
        hcount = 10'd5; vcount = 10'd200; video_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (all_out !== 7'd0) begin
            bad++;
            $display("FAIL reset_state: outputs %b required 0000000", all_out);
        end
        rst = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 7; i++) begin
            pix(hs[i], vs[i]);
            if (all_out !== 7'd0) quiet = 1'b0;
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL sync_quiet: nonzero output during discarded partial frame, required all 0");
        end
        run_frame("first_frame", 10);
    endtask

    task automatic test_quiet();
        gs = 2; bx = 304; by = 224; p1y = 200; p2y = 200;
        for (int f = 0; f < 3; f++) run_frame("quiet", 40);
    endtask

    task automatic test_top_wall();
        gs = 2; bx = 304; by = 4; p1y = 200; p2y = 200;
        run_frame("top_wall", 20);
    endtask

    task automatic test_paddle();
        gs = 2; bx = 20; by = 200; p1y = 200; p2y = 40;
        run_frame("paddle1", 20);
    endtask

    task automatic test_score_p2();
        gs = 2; bx = 0; by = 224; p1y = 300; p2y = 300;
        run_frame("score_p2_play", 10);
        gs = 1; by = 4;
        run_frame("score_p2_serve", 10);
    endtask

    task automatic test_score_p1();
        gs = 2; bx = 608; by = 0; p1y = 300; p2y = 300;
        run_frame("score_p1", 10);
    endtask

    task automatic test_latency();
        gs = 2; bx = 304; by = 4; p1y = 300; p2y = 300;
        apply_scene();
        begin_frame();
        pix(320, 4);
        total++;
        if (CollisionY1 !== 1'b0) begin
            bad++;
            $display("FAIL latency_t1: CollisionY1=%b required 0", CollisionY1);
        end
        pix(400, 100);
        total++;
        if (CollisionY1 !== 1'b1) begin
            bad++;
            $display("FAIL latency_t2: CollisionY1=%b required 1", CollisionY1);
        end
        end_frame("latency");
    endtask

    task automatic test_async();
        gs = 2; bx = 304; by = 4; p1y = 300; p2y = 300;
        apply_scene();
        begin_frame();
        pix(320, 4);
        pix(400, 100);
        total++;
        if (CollisionY1 !== 1'b1) begin
            bad++;
            $display("FAIL async_pre: CollisionY1=%b required 1", CollisionY1);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (all_out !== 7'd0) begin
            bad++;
            $display("FAIL async_clear: outputs %b required 0000000", all_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        gs = 2; bx = 0; by = 4;
        run_frame("after_async", 10);
    endtask

    task automatic test_random();
        for (int f = 0; f < 20; f++) begin
            gs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 2;
            case ($urandom_range(0, 5))
                0:       bx = 0;
                1:       bx = $urandom_range(600, 700);
                2:       bx = $urandom_range(10, 25);
                3:       bx = $urandom_range(583, 594);
                default: bx = $urandom_range(0, 639);
            endcase
            case ($urandom_range(0, 3))
                0:       by = $urandom_range(0, 12);
                1:       by = $urandom_range(436, 470);
                default: by = $urandom_range(0, 511);
            endcase
            p1y = ($urandom_range(0, 1) == 1) ? by + int'($urandom_range(0, 20)) - 10 : int'($urandom_range(0, 447));
            p2y = ($urandom_range(0, 1) == 1) ? by + int'($urandom_range(0, 20)) - 10 : int'($urandom_range(0, 447));
            if (p1y < 0) p1y = 0;
            if (p2y < 0) p2y = 0;
            if (p1y > 511) p1y = 511;
            if (p2y > 511) p2y = 511;
            run_frame("random", 30);
        end
    endtask

    initial begin
        test_reset();
        test_quiet();
        test_top_wall();
        test_paddle();
        test_score_p2();
        test_score_p1();
        test_latency();
        test_async();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
